// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 frame checker: consumes one byte per cycle, checks the
// residue of the whole frame (payload plus the two trailing CRC bytes) and reports status.
module crc16_frame_checker #(
  parameter logic [15:0] POLY    = 16'h8005,
  parameter logic [15:0] INIT    = 16'h0000,
  parameter int          MAX_LEN = 1024,
  parameter int          LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             frame_valid,
  output logic             frame_ok,
  output logic             err_crc,
  output logic             err_short,
  output logic             err_overflow,
  output logic [LEN_W-1:0] frame_len,
  output logic [15:0]      calc_crc,
  output logic [15:0]      rx_crc
);

  localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] SatLenL = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MinLenL = LEN_W'(3);

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      crc_q, crc_d;
  logic [15:0]      hist1_q, hist1_d;
  logic [15:0]      hist2_q, hist2_d;
  logic [15:0]      rxsh_q, rxsh_d;

  logic             xfer;
  logic             in_range;
  logic             last_xfer;
  logic             short_d, ovf_d, crcerr_d;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return r;
  endfunction

  // Bytes past MAX_LEN are drained: counted (saturating) but kept out of the CRC path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    hist1_d   = hist1_q;
    hist2_d   = hist2_q;
    rxsh_d    = rxsh_q;
    in_ready  = ~rst & (state_q != REPORT);
    xfer      = in_valid & in_ready;
    in_range  = (cnt_q < MaxLenL);
    last_xfer = xfer & in_last;
    case (state_q)
      IDLE, RECV: begin
        if (xfer) begin
          cnt_d = (cnt_q == SatLenL) ? cnt_q : cnt_q + LEN_W'(1);
          if (in_range) begin
            crc_d   = crc_byte(crc_q, in_data);
            hist1_d = crc_q;
            hist2_d = hist1_q;
            rxsh_d  = {rxsh_q[7:0], in_data};
          end
          state_d = in_last ? REPORT : RECV;
        end
      end
      REPORT: begin
        state_d = IDLE;
        cnt_d   = '0;
        crc_d   = INIT;
        hist1_d = INIT;
        hist2_d = INIT;
        rxsh_d  = 16'h0000;
      end
      default: state_d = IDLE;
    endcase
    short_d  = (cnt_d < MinLenL);
    ovf_d    = (cnt_d > MaxLenL);
    crcerr_d = (crc_d != 16'h0000) & ~short_d & ~ovf_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= INIT;
      hist1_q <= INIT;
      hist2_q <= INIT;
      rxsh_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      rxsh_q  <= rxsh_d;
    end
  end

  // Status is captured on the last transfer and held until the next frame reports.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ok     <= 1'b0;
      err_crc      <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
      frame_len    <= '0;
      calc_crc     <= 16'h0000;
      rx_crc       <= 16'h0000;
    end else if (last_xfer) begin
      frame_ok     <= ~crcerr_d & ~short_d & ~ovf_d;
      err_crc      <= crcerr_d;
      err_short    <= short_d;
      err_overflow <= ovf_d;
      frame_len    <= cnt_d;
      calc_crc     <= hist2_d;
      rx_crc       <= rxsh_d;
    end
  end

  assign frame_valid = (state_q == REPORT);

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench: two checkers (MAX_LEN 1024 and 8) share one byte stream; expected
// frame status comes from a polynomial long-division model of the CRC.
module tb_crc16_frame_checker;

  typedef logic [7:0] byteQ_t[$];

  typedef struct packed {
    logic [10:0] len;
    logic        ok;
    logic        eCrc;
    logic        eShort;
    logic        eOv;
    logic [15:0] calc;
    logic [15:0] rx;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  inData = 8'h00;
  logic        inValid = 1'b0;
  logic        inLast = 1'b0;

  logic        ready0, fv0, ok0, ec0, es0, eo0;
  logic [10:0] len0;
  logic [15:0] calc0, rx0;
  logic        ready1, fv1, ok1, ec1, es1, eo1;
  logic [10:0] len1;
  logic [15:0] calc1, rx1;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   cycle = 0;
  int   lastAcceptCycle = 0;
  bit   prevLast = 1'b0;
  exp_t expQ0[$];
  exp_t expQ1[$];
  exp_t e0, e1;

  crc16_frame_checker #(.MAX_LEN(1024), .LEN_W(11)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_last(inLast),
    .in_ready(ready0), .frame_valid(fv0), .frame_ok(ok0), .err_crc(ec0), .err_short(es0),
    .err_overflow(eo0), .frame_len(len0), .calc_crc(calc0), .rx_crc(rx0)
  );

  crc16_frame_checker #(.MAX_LEN(8), .LEN_W(11)) dut8 (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_last(inLast),
    .in_ready(ready1), .frame_valid(fv1), .frame_ok(ok1), .err_crc(ec1), .err_short(es1),
    .err_overflow(eo1), .frame_len(len1), .calc_crc(calc1), .rx_crc(rx1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Remainder of M(x)*x^16 mod P(x), i.e. the message followed by 16 zero bits.
  function automatic logic [15:0] polyRem(input byteQ_t f, input int n);
    logic [16:0] rem;
    logic [7:0]  b;
    rem = '0;
    for (int k = 0; k < n + 2; k++) begin
      b = (k < n) ? f[k] : 8'h00;
      for (int j = 7; j >= 0; j--) begin
        rem = {rem[15:0], b[j]};
        if (rem[16]) rem = rem ^ 17'h18005;
      end
    end
    return rem[15:0];
  endfunction

  function automatic exp_t model(input byteQ_t f, input int maxLen);
    exp_t e;
    int   n, m;
    n = f.size();
    m = (n > maxLen) ? maxLen : n;
    e = '0;
    e.len    = 11'((n > maxLen) ? maxLen + 1 : n);
    e.eShort = (n < 3);
    e.eOv    = (n > maxLen);
    e.eCrc   = !e.eShort && !e.eOv && (polyRem(f, m) != 16'h0000);
    e.ok     = !e.eCrc && !e.eShort && !e.eOv;
    e.chk    = !e.eShort;
    if (e.chk) begin
      e.calc = polyRem(f, m - 2);
      e.rx   = {f[m-2], f[m-1]};
    end
    return e;
  endfunction

  function automatic byteQ_t makeFrame(input int len, input bit good);
    byteQ_t      f;
    logic [15:0] c;
    f = {};
    if (good && len >= 3) begin
      for (int k = 0; k < len - 2; k++) f.push_back(8'($urandom));
      c = polyRem(f, len - 2);
      f.push_back(c[15:8]);
      f.push_back(c[7:0]);
    end else begin
      for (int k = 0; k < len; k++) f.push_back(8'($urandom));
    end
    return f;
  endfunction

  task automatic finishRun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkFrame(input string tag, input exp_t e, input logic [10:0] len,
                            input logic ok, input logic ec, input logic es, input logic eo,
                            input logic [15:0] calc, input logic [15:0] rx);
    checkOutput({tag, ".frame_len"}, 32'(len), 32'(e.len));
    checkOutput({tag, ".frame_ok"}, 32'(ok), 32'(e.ok));
    checkOutput({tag, ".err_crc"}, 32'(ec), 32'(e.eCrc));
    checkOutput({tag, ".err_short"}, 32'(es), 32'(e.eShort));
    checkOutput({tag, ".err_overflow"}, 32'(eo), 32'(e.eOv));
    if (e.chk) begin
      checkOutput({tag, ".calc_crc"}, 32'(calc), 32'(e.calc));
      checkOutput({tag, ".rx_crc"}, 32'(rx), 32'(e.rx));
    end
  endtask

  task automatic unexpectedPulse(input string tag);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s.unexpectedPulse: frame_valid=1, expected no pulse", tag);
  endtask

  // Monitor: every frame_valid pulse pops the oldest expected status for that checker.
  always @(negedge clk) begin
    if (!rst && fv0) begin
      if (expQ0.size() == 0) unexpectedPulse("u0");
      else begin
        e0 = expQ0.pop_front();
        checkFrame("u0", e0, len0, ok0, ec0, es0, eo0, calc0, rx0);
        checkOutput("u0.latency", 32'(cycle), 32'(lastAcceptCycle + 1));
      end
    end
    if (!rst && fv1) begin
      if (expQ1.size() == 0) unexpectedPulse("u8");
      else begin
        e1 = expQ1.pop_front();
        checkFrame("u8", e1, len1, ok1, ec1, es1, eo1, calc1, rx1);
      end
    end
  end

  // Sends a frame byte by byte; cut>0 sends only that many bytes with no in_last.
  task automatic applyStimulus(input byteQ_t f, input int maxGap, input int cut);
    int n, gap, stalls, expStalls;
    bit accepted;
    n = (cut > 0) ? cut : f.size();
    if (cut == 0) begin
      expQ0.push_back(model(f, 1024));
      expQ1.push_back(model(f, 8));
    end
    for (int i = 0; i < n; i++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      if (gap > 0) begin
        inValid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      inData   = f[i];
      inLast   = (cut == 0) && (i == n - 1);
      inValid  = 1'b1;
      stalls   = 0;
      accepted = 1'b0;
      while (!accepted) begin
        @(negedge clk);
        if (ready0) begin
          accepted = 1'b1;
          if (inLast) lastAcceptCycle = cycle;
        end else stalls++;
        @(posedge clk);
        #1;
        if (stalls > 4) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL readyTimeout: in_ready low %0d cycles, expected at most 1", stalls);
          finishRun();
        end
      end
      expStalls = (prevLast && gap == 0) ? 1 : 0;
      checkOutput("readyBubble", 32'(stalls), 32'(expStalls));
      prevLast = inLast;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic doReset();
    inValid = 1'b0;
    inLast  = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst.in_ready", 32'(ready0), 32'd0);
    checkOutput("rst.u8.in_ready", 32'(ready1), 32'd0);
    checkOutput("rst.frame_valid", 32'(fv0), 32'd0);
    checkOutput("rst.frame_ok", 32'(ok0), 32'd0);
    checkOutput("rst.errs", 32'({ec0, es0, eo0}), 32'd0);
    checkOutput("rst.frame_len", 32'(len0), 32'd0);
    checkOutput("rst.calc_crc", 32'(calc0), 32'd0);
    checkOutput("rst.rx_crc", 32'(rx0), 32'd0);
    checkOutput("rst.u8.status", 32'({fv1, ok1, ec1, es1, eo1, len1}), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst.readyAfter", 32'(ready0), 32'd1);
    @(posedge clk);
    #1;
    prevLast = 1'b0;
  endtask

  initial begin
    #1ms;
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    finishRun();
  end

  initial begin
    byteQ_t a, b, f;
    a = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hFE, 8'hE8};
    b = a;
    b[10] = 8'hE9;
    checkOutput("modelCheckValue", 32'(polyRem(a, 9)), 32'h0000FEE8);

    doReset();
    $display("[TB] check vector, corrupted vector, short frames");
    applyStimulus(a, 0, 0);
    applyStimulus(b, 0, 0);
    f = '{8'h00, 8'h00};
    applyStimulus(f, 0, 0);
    f = '{8'h5A};
    applyStimulus(f, 0, 0);

    $display("[TB] overflow and length boundaries");
    applyStimulus(makeFrame(12, 1'b1), 0, 0);
    applyStimulus(makeFrame(8, 1'b1), 0, 0);
    applyStimulus(makeFrame(9, 1'b1), 0, 0);
    applyStimulus(makeFrame(3, 1'b1), 0, 0);

    $display("[TB] back-to-back and gapped frames");
    applyStimulus(a, 0, 0);
    applyStimulus(a, 0, 0);
    applyStimulus(a, 3, 0);
    applyStimulus(a, 3, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(a, 0, 5);
    doReset();
    applyStimulus(a, 0, 0);

    $display("[TB] randomized frames");
    for (int t = 0; t < 60; t++) begin
      f = makeFrame(int'($urandom_range(20, 1)), 1'($urandom_range(1, 0)));
      applyStimulus(f, (t % 3 == 0) ? 2 : 0, 0);
    end

    $display("[TB] long frames at MAX_LEN 1024");
    applyStimulus(makeFrame(1024, 1'b1), 0, 0);
    applyStimulus(makeFrame(1030, 1'b1), 0, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("u0.queueEmpty", 32'(expQ0.size()), 32'd0);
    checkOutput("u8.queueEmpty", 32'(expQ1.size()), 32'd0);
    finishRun();
  end

endmodule
